// File: rtl/fir_engine_ctrl_pkg.sv
// Shared types and helpers for the FIR engine sequencer: FSM state encoding,
// byte-enable constants and a ceil-log2 used to size the RAM word index.
package fir_engine_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_WAIT_IN,
      S_MAC,
      S_OUT,
      S_DONE
   } fir_state_e;

   localparam logic [3:0] WE_ALL  = 4'hF;
   localparam logic [3:0] WE_NONE = 4'h0;

   function automatic int fir_log2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_engine_ctrl_mac.sv
// Registered multiply-accumulate for the FIR datapath; accumulator wraps modulo 2^W.
module fir_engine_ctrl_mac #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] coef,
   input  logic [W-1:0] sample,
   output logic [W-1:0] acc
);

   logic [W-1:0] prod;

   // The low W bits of a two's-complement product match the unsigned product.
   assign prod = coef * sample;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/fir_engine_ctrl.sv
// FIR sequencer: circular sample RAM, tap walk, MAC and stream/ap control.
// Optional FIR_TLAST_CHECK_EN adds a sticky tlast_err output.
module fir_engine_ctrl
   import fir_engine_ctrl_pkg::*;
#(
   parameter int pADDR_WIDTH = 12,
   parameter int pDATA_WIDTH = 32,
   parameter int Tape_Num    = 11,
   parameter int RAM_ADDR    = fir_log2(Tape_Num)
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   ap_start,
   input  logic [pDATA_WIDTH-1:0] data_length,
   output logic                   ap_idle,
   output logic                   ap_done,
   output logic [RAM_ADDR-1:0]    fir_raddr,
   input  logic [pDATA_WIDTH-1:0] fir_rdata,
   output logic [3:0]             data_WE,
   output logic                   data_EN,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic [pDATA_WIDTH-1:0] data_Di,
   input  logic [pDATA_WIDTH-1:0] data_Do,
`ifdef FIR_TLAST_CHECK_EN
   output logic                   tlast_err,
`endif
   input  logic                   ss_tvalid,
   input  logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tlast,
   output logic                   ss_tready,
   output logic                   sm_tvalid,
   output logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tlast,
   input  logic                   sm_tready
);

   localparam int CW = RAM_ADDR + 1;
   localparam logic [CW-1:0]       LAST_IDX = CW'(Tape_Num - 1);
   localparam logic [CW-1:0]       MAC_END  = CW'(Tape_Num);
   localparam logic [RAM_ADDR-1:0] N_RA     = RAM_ADDR'(Tape_Num);
   localparam logic [RAM_ADDR-1:0] WRAP_RA  = RAM_ADDR'(Tape_Num - 1);

   fir_state_e state, next_state;

   logic [CW-1:0]          cnt;
   logic [RAM_ADDR-1:0]    wptr;
   logic [pDATA_WIDTH-1:0] out_cnt;
   logic [RAM_ADDR-1:0]    m_idx;
   logic [RAM_ADDR-1:0]    ram_idx;
   logic                   last_out;
   logic                   start_acc;
   logic                   in_hs;
   logic                   out_hs;
   logic                   mac_en;
   logic [pDATA_WIDTH-1:0] acc;

   assign m_idx    = cnt[RAM_ADDR-1:0];
   assign last_out = (out_cnt == data_length - 1'b1);

   // Stream handshakes: a beat moves on a rising edge where tvalid and tready are
   // both high; OUT holds sm_tdata/sm_tlast unchanged until that edge.
   always_comb begin
      next_state = state;
      start_acc  = 1'b0;
      in_hs      = 1'b0;
      out_hs     = 1'b0;
      case (state)
         S_IDLE, S_DONE: begin
            if (ap_start && ap_idle) begin
               start_acc  = 1'b1;
               next_state = S_CLEAR;
            end
         end
         S_CLEAR: begin
            if (cnt == LAST_IDX) next_state = (data_length == '0) ? S_DONE : S_WAIT_IN;
         end
         S_WAIT_IN: begin
            if (ss_tvalid) begin
               in_hs      = 1'b1;
               next_state = S_MAC;
            end
         end
         S_MAC: begin
            if (cnt == MAC_END) next_state = S_OUT;
         end
         S_OUT: begin
            if (sm_tready) begin
               out_hs     = 1'b1;
               next_state = last_out ? S_DONE : S_WAIT_IN;
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   always_comb begin
      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tlast  = 1'b0;
      data_EN   = 1'b0;
      data_WE   = WE_NONE;
      data_Di   = '0;
      ram_idx   = '0;
      fir_raddr = '0;
      mac_en    = 1'b0;
      case (state)
         S_CLEAR: begin
            data_EN = 1'b1;
            data_WE = WE_ALL;
            ram_idx = m_idx;
         end
         S_WAIT_IN: begin
            ss_tready = 1'b1;
            data_EN   = 1'b1;
            data_WE   = in_hs ? WE_ALL : WE_NONE;
            data_Di   = ss_tdata;
            ram_idx   = wptr;
         end
         S_MAC: begin
            data_EN   = 1'b1;
            fir_raddr = m_idx;
            // Newest sample pairs with tap 0, walking backwards around the ring.
            ram_idx   = (wptr >= m_idx) ? (wptr - m_idx) : (wptr + N_RA - m_idx);
            mac_en    = (cnt != '0);
         end
         S_OUT: begin
            sm_tvalid = 1'b1;
            sm_tlast  = last_out;
         end
         default: ;
      endcase
   end

   assign data_A   = {{(pADDR_WIDTH - RAM_ADDR - 2){1'b0}}, ram_idx, 2'b00};
   assign sm_tdata = acc;

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) state <= S_IDLE;
      else             state <= next_state;
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         cnt     <= '0;
         wptr    <= '0;
         out_cnt <= '0;
         ap_idle <= 1'b1;
         ap_done <= 1'b0;
      end else begin
         if (next_state != state)                 cnt <= '0;
         else if (state == S_CLEAR || state == S_MAC) cnt <= cnt + 1'b1;

         if (start_acc) begin
            wptr    <= '0;
            out_cnt <= '0;
            ap_idle <= 1'b0;
            ap_done <= 1'b0;
         end else begin
            if (out_hs) begin
               wptr    <= (wptr == WRAP_RA) ? '0 : wptr + 1'b1;
               out_cnt <= out_cnt + 1'b1;
            end
            if (next_state == S_DONE && state != S_DONE) begin
               ap_idle <= 1'b1;
               ap_done <= 1'b1;
            end
         end
      end
   end

   fir_engine_ctrl_mac #(.W(pDATA_WIDTH)) u_mac (
      .clk    (axis_clk),
      .rst_n  (axis_rst_n),
      .clr    (in_hs),
      .en     (mac_en),
      .coef   (fir_rdata),
      .sample (data_Do),
      .acc    (acc)
   );

`ifdef FIR_TLAST_CHECK_EN
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n)                          tlast_err <= 1'b0;
      else if (start_acc)                       tlast_err <= 1'b0;
      else if (in_hs && (ss_tlast != last_out)) tlast_err <= 1'b1;
   end
`else
   logic unused_tlast;
   assign unused_tlast = ss_tlast;
`endif

endmodule

// File: tb/tb_fir_engine_ctrl.sv
// Directed bench for fir_engine_ctrl with behavioural tap/data BRAM models.
module tb_fir_engine_ctrl;

   localparam int N = 11;
   localparam int TAPS [N] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

   logic        clk;
   logic        axis_rst_n;
   logic        ap_start;
   logic [31:0] data_length;
   logic        ap_idle, ap_done;
   logic [3:0]  fir_raddr;
   logic [31:0] fir_rdata;
   logic [3:0]  data_WE;
   logic        data_EN;
   logic [11:0] data_A;
   logic [31:0] data_Di, data_Do;
   logic        ss_tvalid, ss_tlast, ss_tready;
   logic [31:0] ss_tdata;
   logic        sm_tvalid, sm_tlast, sm_tready;
   logic [31:0] sm_tdata;
`ifdef FIR_TLAST_CHECK_EN
   logic        tlast_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int v_cnt = 0;
   int r_cnt = 0;
   logic [31:0] exp_q [$];
   logic [31:0] last_q [$];
   int in_vec  [16];
   int out_vec [16];
   logic [31:0] dmem [N];

   fir_engine_ctrl dut (
      .axis_clk    (clk),
      .axis_rst_n  (axis_rst_n),
      .ap_start    (ap_start),
      .data_length (data_length),
      .ap_idle     (ap_idle),
      .ap_done     (ap_done),
      .fir_raddr   (fir_raddr),
      .fir_rdata   (fir_rdata),
      .data_WE     (data_WE),
      .data_EN     (data_EN),
      .data_A      (data_A),
      .data_Di     (data_Di),
      .data_Do     (data_Do),
`ifdef FIR_TLAST_CHECK_EN
      .tlast_err   (tlast_err),
`endif
      .ss_tvalid   (ss_tvalid),
      .ss_tdata    (ss_tdata),
      .ss_tlast    (ss_tlast),
      .ss_tready   (ss_tready),
      .sm_tvalid   (sm_tvalid),
      .sm_tdata    (sm_tdata),
      .sm_tlast    (sm_tlast),
      .sm_tready   (sm_tready)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // BRAM models, 1-cycle read latency
   always @(posedge clk) begin
      fir_rdata <= (int'(fir_raddr) < N) ? 32'(TAPS[fir_raddr]) : 32'd0;
      if (data_EN && int'(data_A[5:2]) < N) begin
         data_Do <= dmem[data_A[5:2]];
         if (data_WE == 4'hF) dmem[data_A[5:2]] <= data_Di;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag,
                  $signed(obs), obs, $signed(exp), exp);
      end
   endtask

   // scoreboard: outputs move on edges following a negedge with valid&ready
   always @(negedge clk) begin
      if (axis_rst_n) begin
         if (sm_tvalid) v_cnt++;
         if (ss_tready) r_cnt++;
         if (sm_tvalid && sm_tready) begin
            if (exp_q.size() == 0) begin
               check("extra_out", 32'd1, 32'd0);
            end else begin
               check("out_data", sm_tdata, exp_q.pop_front());
               check("out_last", {31'd0, sm_tlast}, last_q.pop_front());
            end
         end
      end
   end

   // driver tasks; all are entered and left at posedge+1
   task automatic start_pulse();
      ap_start = 1'b1;
      @(posedge clk); #1;
      ap_start = 1'b0;
   endtask

   task automatic send_sample(input logic [31:0] d, input logic last);
      bit got = 1'b0;
      ss_tvalid = 1'b1;
      ss_tdata  = d;
      ss_tlast  = last;
      for (int k = 0; k < 100 && !got; k++) begin
         @(negedge clk);
         got = ss_tready;
         @(posedge clk); #1;
      end
      ss_tvalid = 1'b0;
      if (!got) check("ss_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic take_outputs(input int len, input int stall_at);
      for (int i = 0; i < len; i++) begin
         bit got = 1'b0;
         for (int k = 0; k < 100 && !got; k++) begin
            if (sm_tvalid) got = 1'b1;
            else begin
               @(posedge clk); #1;
            end
         end
         if (!got) begin
            check("sm_valid_timeout", 32'd0, 32'd1);
            return;
         end
         if (i == stall_at) begin
            for (int s = 0; s < 5; s++) begin
               check("stall_data", sm_tdata, 32'(out_vec[i]));
               check("stall_ss_tready", {31'd0, ss_tready}, 32'd0);
               @(posedge clk); #1;
            end
         end
         sm_tready = 1'b1;
         @(posedge clk); #1;
         sm_tready = 1'b0;
      end
   endtask

   task automatic run_stream(input int len, input int stall_at);
      bit fin = 1'b0;
      data_length = 32'(len);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back(32'(out_vec[i]));
         last_q.push_back((i == len - 1) ? 32'd1 : 32'd0);
      end
      start_pulse();
      check("busy_idle", {31'd0, ap_idle}, 32'd0);
      fork
         for (int i = 0; i < len; i++) send_sample(32'(in_vec[i]), i == len - 1);
         take_outputs(len, stall_at);
      join
      for (int k = 0; k < 50 && !fin; k++) begin
         if (ap_done) fin = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("run_done", {31'd0, ap_done}, 32'd1);
      check("run_idle", {31'd0, ap_idle}, 32'd1);
      check("drain", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      last_q.delete();
   endtask

   task automatic set_impulse(input int len);
      for (int i = 0; i < 16; i++) begin
         in_vec[i]  = (i == 0) ? 1 : 0;
         out_vec[i] = (i < N && i < len) ? TAPS[i] : 0;
      end
   endtask

   initial begin
      bit fin;
      ap_start = 0; data_length = 0; ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0;
      sm_tready = 0; axis_rst_n = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ap_idle",   {31'd0, ap_idle},   32'd1);
      check("rst_ap_done",   {31'd0, ap_done},   32'd0);
      check("rst_ss_tready", {31'd0, ss_tready}, 32'd0);
      check("rst_sm_tvalid", {31'd0, sm_tvalid}, 32'd0);
      check("rst_sm_tlast",  {31'd0, sm_tlast},  32'd0);
      check("rst_sm_tdata",  sm_tdata,           32'd0);
      check("rst_data_EN",   {31'd0, data_EN},   32'd0);
      check("rst_data_WE",   {28'd0, data_WE},   32'd0);
      check("rst_fir_raddr", {28'd0, fir_raddr}, 32'd0);
      axis_rst_n = 1;
      @(posedge clk); #1;

      // impulse response: taps then five zeros, tlast only on 16th
      set_impulse(16);
      run_stream(16, -1);

      // backpressure on output index 3
      in_vec[0:5]  = '{2, 0, 0, 1, 0, 0};
      out_vec[0:5] = '{0, -20, -18, 46, 102, 117};
      run_stream(6, 3);

      // zero-length run
      data_length = 0;
      v_cnt = 0; r_cnt = 0;
      start_pulse();
      fin = 1'b0;
      for (int k = 0; k < N + 2 && !fin; k++) begin
         if (ap_done) fin = 1'b1;
         else begin
            @(posedge clk); #1;
         end
      end
      check("len0_done", {31'd0, ap_done}, 32'd1);
      check("len0_idle", {31'd0, ap_idle}, 32'd1);
      check("len0_no_valid", 32'(v_cnt), 32'd0);
      check("len0_no_ready", 32'(r_cnt), 32'd0);

      // back-to-back: constant 100 then impulse, no residue across runs
      for (int i = 0; i < 16; i++) in_vec[i] = 100;
      out_vec[0:10] = '{0, -1000, -1900, 400, 6000, 12300, 17900, 20200, 19300, 18300, 18300};
      run_stream(11, -1);
      set_impulse(11);
      run_stream(11, -1);

      // asynchronous reset in MAC cycle 5
      data_length = 4;
      start_pulse();
      send_sample(32'd7, 1'b0);
      repeat (5) begin
         @(posedge clk); #1;
      end
      check("mac_raddr", {28'd0, fir_raddr}, 32'd5);
      axis_rst_n = 0;
      #1;
      check("mrst_ap_idle",   {31'd0, ap_idle},   32'd1);
      check("mrst_ap_done",   {31'd0, ap_done},   32'd0);
      check("mrst_ss_tready", {31'd0, ss_tready}, 32'd0);
      check("mrst_sm_tvalid", {31'd0, sm_tvalid}, 32'd0);
      check("mrst_data_EN",   {31'd0, data_EN},   32'd0);
      check("mrst_fir_raddr", {28'd0, fir_raddr}, 32'd0);
      check("mrst_sm_tdata",  sm_tdata,           32'd0);
      @(posedge clk); #1;
      axis_rst_n = 1;
      @(posedge clk); #1;
      set_impulse(11);
      run_stream(11, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
